// File: rtl/mmio_bridge.sv
// Byte-wide CPU memory port bridge: routes accesses to the external RAM or to the
// memory-mapped IO block (UART TX FIFO, RX pop, cycle counter, program stop).
module mmio_bridge #(
  parameter int TX_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        tx_overflow,
  output logic        program_finish
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [17:0] ADDR_UART = 18'h30000;
  localparam logic [17:0] ADDR_CNT0 = 18'h30004;
  localparam logic [17:0] ADDR_CNT1 = 18'h30005;
  localparam logic [17:0] ADDR_CNT2 = 18'h30006;
  localparam logic [17:0] ADDR_CNT3 = 18'h30007;

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DONE} state_t;

  logic [17:0] addr;
  logic        is_ram;
  logic        act_rd;
  logic        act_wr;
  logic        unused_addr_bits;

  assign addr             = mem_a[17:0];
  assign is_ram           = ~mem_a[17];
  assign act_rd           = rdy_in & ~mem_wr;
  assign act_wr           = rdy_in & mem_wr;
  assign unused_addr_bits = ^mem_a[31:18];

  assign ram_a     = mem_a[16:0];
  assign ram_wdata = mem_dout;
  assign ram_we    = act_wr & is_ram;

  // ---------------------------------------------------------------------------
  // Read path: one-cycle latency for both RAM and IO
  // ---------------------------------------------------------------------------
  logic        sel_ram_q;
  logic [7:0]  io_rdata_q;
  logic [7:0]  io_rdata_d;
  logic        snap_load;
  logic [31:0] cnt_q;
  logic [31:0] snap_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    io_rdata_d = '0;
    snap_load  = 1'b0;
    if (act_rd) begin
      case (addr)
        ADDR_UART: if (rx_valid) io_rdata_d = rx_data;
        ADDR_CNT0: begin
          io_rdata_d = cnt_q[7:0];
          snap_load  = 1'b1;
        end
        ADDR_CNT1: io_rdata_d = snap_q[15:8];
        ADDR_CNT2: io_rdata_d = snap_q[23:16];
        ADDR_CNT3: io_rdata_d = snap_q[31:24];
        default:   io_rdata_d = '0;
      endcase
    end
  end

  assign rx_ready = act_rd & (addr == ADDR_UART) & rx_valid;
  assign mem_din  = sel_ram_q ? ram_rdata : io_rdata_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_ram_q  <= 1'b0;
      io_rdata_q <= '0;
      cnt_q      <= '0;
      snap_q     <= '0;
    end else begin
      sel_ram_q  <= act_rd & is_ram;
      io_rdata_q <= io_rdata_d;
      cnt_q      <= cnt_q + 32'd1;
      if (snap_load) snap_q <= cnt_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Program-stop state machine
  // ---------------------------------------------------------------------------
  state_t             state_q;
  state_t             state_d;
  logic               tx_wr_en;
  logic [CNT_W-1:0]   count_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (act_wr && addr == ADDR_CNT0) state_d = ST_FLUSH;
      ST_FLUSH: if (count_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    tx_wr_en       = (state_q == ST_RUN);
    program_finish = (state_q == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       fifo_q [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             fifo_full;
  logic [7:0]       push_byte;

  assign push_req  = act_wr & tx_wr_en &
                     (((addr == ADDR_UART) && (mem_dout != 8'h00)) || (addr == ADDR_CNT0));
  assign push_byte = (addr == ADDR_CNT0) ? 8'h00 : mem_dout;
  assign fifo_full = (count_q == CNT_W'(TX_DEPTH));
  assign pop       = tx_valid & tx_ready;
  // A pop in the same cycle frees the slot, so a push at full is only dropped without one.
  assign push_ok   = push_req & (~fifo_full | pop);

  assign tx_valid       = (count_q != '0);
  assign tx_data        = fifo_q[rd_ptr_q];
  assign io_buffer_full = (count_q >= CNT_W'(TX_DEPTH - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (push_req && !push_ok) tx_overflow <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk_in) begin
    if (push_ok) fifo_q[wr_ptr_q] <= push_byte;
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: vector table, directed multi-cycle
// sequences and a randomized run against a queue-based reference model.
module tb_mmio_bridge;

  localparam int DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, mem_din;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        ram_we;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, tx_overflow, program_finish;

  always #5 clk_in = ~clk_in;

  mmio_bridge #(.TX_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
    .io_buffer_full(io_buffer_full),
    .ram_a(ram_a), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_overflow(tx_overflow), .program_finish(program_finish)
  );

  // Synchronous RAM with one-cycle read latency
  logic [7:0] ram_mem [0:131071] = '{default: 8'h00};
  always @(posedge clk_in) begin
    if (ram_we) ram_mem[ram_a] <= ram_wdata;
    ram_rdata <= ram_mem[ram_a];
  end

  // UART TX sink: records every accepted byte
  logic [7:0] tx_out [$];
  always @(negedge clk_in) begin
    if (!rst_in && tx_valid && tx_ready) tx_out.push_back(tx_data);
  end

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cpu(input logic rdy, input logic wr, input logic [31:0] a, input logic [7:0] d);
    rdy_in = rdy; mem_wr = wr; mem_a = a; mem_dout = d;
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    cyc = 0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    cpu(0, 0, 0, 0);
    tx_ready = 1'b1;
    while (tx_valid && n < 64) begin
      tick();
      n++;
    end
    check({tag, " drain_done"}, tx_valid, 1'b0);
  endtask

  task automatic compare_tx(input string tag, input int mark, input logic [7:0] exp_q [$]);
    check({tag, " tx_count"}, tx_out.size() - mark, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (mark + i < tx_out.size())
        check($sformatf("%s tx_byte%0d", tag, i), tx_out[mark + i], exp_q[i]);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic        rxv;
    logic [7:0]  rxd;
    logic        exp_we;
    logic        exp_rxr;
    logic [7:0]  exp_din;
  } vec_t;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [$];
    logic [7:0]  exp_q [$];
    int          mark;

    vecs.push_back('{1'b1, 1'b1, 32'h0000_0010, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0010, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A});
    vecs.push_back('{1'b1, 1'b1, 32'h0002_0010, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 32'h0002_0010, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 32'h0003_0010, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 1'b1, 32'h0001_FFFF, 8'hC3, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 32'h0001_FFFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hC3});
    vecs.push_back('{1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h33, 1'b0, 1'b1, 8'h33});
    vecs.push_back('{1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'h99, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h44, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 1'b1, 32'hFFFC_0010, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11});
    vecs.push_back('{1'b1, 1'b0, 32'h0001_FFFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hC3});

    tx_ready = 1'b0; rx_valid = 1'b1; rx_data = 8'h00;

    // Reset state; the RAM enable stays combinational throughout reset
    cpu(1, 1, 32'h0000_0050, 8'hEE);
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset ram_we", ram_we, 1'b1);
    cpu(0, 0, 0, 0);
    #1;
    check("reset ram_we_low", ram_we, 1'b0);
    check("reset mem_din", mem_din, 8'h00);
    check("reset tx_valid", tx_valid, 1'b0);
    check("reset io_buffer_full", io_buffer_full, 1'b0);
    check("reset rx_ready", rx_ready, 1'b0);
    check("reset tx_overflow", tx_overflow, 1'b0);
    check("reset program_finish", program_finish, 1'b0);
    rst_in = 1'b0;
    cyc = 0;
    rx_valid = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      cpu(vecs[i].rdy, vecs[i].wr, vecs[i].a, vecs[i].d);
      rx_valid = vecs[i].rxv; rx_data = vecs[i].rxd;
      #1;
      check($sformatf("vec%0d ram_we", i), ram_we, vecs[i].exp_we);
      check($sformatf("vec%0d rx_ready", i), rx_ready, vecs[i].exp_rxr);
      if (vecs[i].exp_we) check($sformatf("vec%0d ram_a", i), ram_a, vecs[i].a[16:0]);
      tick();
      check($sformatf("vec%0d mem_din", i), mem_din, vecs[i].exp_din);
    end
    rx_valid = 1'b0;

    // TX ordering with zero-byte suppression
    do_reset();
    mark = tx_out.size();
    tx_ready = 1'b1;
    cpu(1, 1, 32'h0003_0000, 8'h41); tick();
    check("tx first_valid", tx_valid, 1'b1);
    check("tx first_data", tx_data, 8'h41);
    cpu(1, 1, 32'h0003_0000, 8'h00); tick();
    cpu(1, 1, 32'h0003_0000, 8'h42); tick();
    drain("tx");
    exp_q.delete(); exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    compare_tx("tx", mark, exp_q);

    // Fill, near-full flag, push+pop at full, overflow, drain order
    do_reset();
    mark = tx_out.size();
    tx_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      cpu(1, 1, 32'h0003_0000, 8'h10 + 8'(k)); tick();
      check($sformatf("fill io_buffer_full_after_%0d", k + 1), io_buffer_full, (k + 1 >= DEPTH - 1));
    end
    check("fill no_overflow", tx_overflow, 1'b0);
    tx_ready = 1'b1;
    cpu(1, 1, 32'h0003_0000, 8'h19); tick();
    check("full push_pop no_overflow", tx_overflow, 1'b0);
    tx_ready = 1'b0;
    cpu(1, 1, 32'h0003_0000, 8'h1A); tick();
    check("full push overflow", tx_overflow, 1'b1);
    drain("fill");
    check("fill overflow_sticky", tx_overflow, 1'b1);
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(8'h10 + 8'(k));
    exp_q.push_back(8'h19);
    compare_tx("fill", mark, exp_q);

    // Counter bytes and snapshot consistency
    do_reset();
    cpu(0, 0, 0, 0);
    while (cyc != 5) tick();
    cpu(1, 0, 32'h0003_0004, 8'h00); tick();
    check("cnt at_5", mem_din, 8'h05);
    cpu(0, 0, 0, 0);
    while (cyc != 32'h2FF && cyc < 2000) tick();
    cpu(1, 0, 32'h0003_0004, 8'h00); tick();
    check("cnt byte0", mem_din, 8'hFF);
    cpu(1, 0, 32'h0003_0005, 8'h00); tick();
    check("cnt byte1", mem_din, 8'h02);
    cpu(1, 0, 32'h0003_0006, 8'h00); tick();
    check("cnt byte2", mem_din, 8'h00);
    cpu(1, 0, 32'h0003_0007, 8'h00); tick();
    check("cnt byte3", mem_din, 8'h00);

    // Program stop: queued bytes drain, then 0x00, later writes ignored
    do_reset();
    mark = tx_out.size();
    tx_ready = 1'b0;
    cpu(1, 1, 32'h0003_0000, 8'h61); tick();
    cpu(1, 1, 32'h0003_0000, 8'h62); tick();
    cpu(1, 1, 32'h0003_0000, 8'h63); tick();
    cpu(1, 1, 32'h0003_0004, 8'hAA); tick();
    cpu(1, 1, 32'h0003_0000, 8'h41); tick();
    cpu(1, 1, 32'h0003_0004, 8'h00); tick();
    rx_valid = 1'b1; rx_data = 8'h5C;
    cpu(1, 0, 32'h0003_0000, 8'h00);
    #1;
    check("flush rx_ready", rx_ready, 1'b1);
    tick();
    rx_valid = 1'b0;
    check("flush rx_data", mem_din, 8'h5C);
    check("flush not_finished", program_finish, 1'b0);
    drain("flush");
    check("flush finish_not_yet", program_finish, 1'b0);
    tick();
    check("flush finish", program_finish, 1'b1);
    exp_q.delete();
    exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63); exp_q.push_back(8'h00);
    compare_tx("flush", mark, exp_q);
    cpu(1, 1, 32'h0003_0000, 8'h55); tick();
    cpu(1, 1, 32'h0003_0004, 8'h00); tick();
    check("done write_ignored", tx_valid, 1'b0);
    check("done sticky", program_finish, 1'b1);

    // Reset in the middle of a flush discards undrained bytes
    do_reset();
    tx_ready = 1'b0;
    cpu(1, 1, 32'h0003_0000, 8'h71); tick();
    cpu(1, 1, 32'h0003_0000, 8'h72); tick();
    cpu(1, 1, 32'h0003_0004, 8'h00); tick();
    cpu(0, 0, 0, 0);
    do_reset();
    check("midflush tx_valid", tx_valid, 1'b0);
    check("midflush program_finish", program_finish, 1'b0);
    mark = tx_out.size();
    tx_ready = 1'b1;
    cpu(1, 1, 32'h0003_0000, 8'h44); tick();
    drain("midflush");
    exp_q.delete(); exp_q.push_back(8'h44);
    compare_tx("midflush", mark, exp_q);

    // Randomized run against a transaction-level model
    begin
      logic [7:0]  q_m [$];
      logic [7:0]  ram_m [int];
      logic [31:0] snap_m;
      logic [7:0]  exp_din;
      logic        ovf_m;
      logic        rdy, wr, rxv, txr;
      logic [31:0] a;
      logic [17:0] la;
      logic [7:0]  d, rxd, din_next;
      int          r;

      do_reset();
      snap_m = '0; exp_din = '0; ovf_m = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2: a = 32'h100 + 32'($urandom_range(0, 63));
          3:       a = ($urandom() & 32'hFFFC_0000) | (32'h1FF00 + 32'($urandom_range(0, 63)));
          4:       a = 32'h2_0000 + 32'($urandom_range(0, 31));
          5, 6:    a = 32'h3_0000;
          7:       a = 32'h3_0004 + 32'($urandom_range(0, 3));
          8:       a = 32'h3_0008 + 32'($urandom_range(0, 16'hFFF0));
          default: a = 32'h3_0001 + 32'($urandom_range(0, 2));
        endcase
        la  = a[17:0];
        wr  = 1'($urandom_range(0, 1));
        if (la == 18'h30004) wr = 1'b0;
        rdy = ($urandom_range(0, 7) != 0);
        d   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
        rxv = 1'($urandom_range(0, 1));
        rxd = 8'($urandom());
        txr = (i < 1500) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);

        cpu(rdy, wr, a, d); rx_valid = rxv; rx_data = rxd; tx_ready = txr;
        #1;
        check("rnd mem_din", mem_din, exp_din);
        check("rnd ram_we", ram_we, rdy & wr & ~a[17]);
        check("rnd rx_ready", rx_ready, rdy & ~wr & (la == 18'h30000) & rxv);
        check("rnd tx_valid", tx_valid, q_m.size() != 0);
        if (q_m.size() != 0) check("rnd tx_data", tx_data, q_m[0]);
        check("rnd io_buffer_full", io_buffer_full, q_m.size() >= DEPTH - 1);
        check("rnd tx_overflow", tx_overflow, ovf_m);

        din_next = 8'h00;
        if (rdy && !wr) begin
          if (!a[17]) din_next = ram_m.exists(int'(a[16:0])) ? ram_m[int'(a[16:0])] : 8'h00;
          else if (la == 18'h30000) din_next = rxv ? rxd : 8'h00;
          else if (la == 18'h30004) begin din_next = cyc[7:0]; snap_m = cyc; end
          else if (la == 18'h30005) din_next = snap_m[15:8];
          else if (la == 18'h30006) din_next = snap_m[23:16];
          else if (la == 18'h30007) din_next = snap_m[31:24];
        end
        if (rdy && wr && !a[17]) ram_m[int'(a[16:0])] = d;
        if (q_m.size() != 0 && txr) void'(q_m.pop_front());
        if (rdy && wr && la == 18'h30000 && d != 8'h00) begin
          if (q_m.size() < DEPTH) q_m.push_back(d);
          else ovf_m = 1'b1;
        end
        exp_din = din_next;
        tick();
      end
      check("rnd final mem_din", mem_din, exp_din);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Memory/IO bridge sitting directly downstream of the CPU core's byte-wide memory port (`mem_a`/`mem_dout`/`mem_wr`/`mem_din`/`io_buffer_full`). It routes each access to the 128 KB synchronous RAM or to the memory-mapped IO space (`mem_a[17:16]==2'b11`). It owns the UART TX FIFO, the RX pop path, the free-running cycle counter and program-stop sequencing. Every read returns data on `mem_din` exactly one cycle after the request, matching the core's fixed read latency.

## Interface
- `TX_DEPTH`, 8: TX FIFO entries; power of two, at least 4.
- `clk_in` input 1: single clock.
- `rst_in` input 1: synchronous, active-high reset.
- `rdy_in` input 1: CPU ready; when low, CPU-side accesses have no side effects.
- `mem_a` input 32: CPU byte address; bits 17:0 decoded.
- `mem_dout` input 8: CPU write data.
- `mem_wr` input 1: 1 = write, 0 = read.
- `mem_din` output 8: read data to CPU, valid the cycle after the request.
- `io_buffer_full` output 1: TX FIFO near-full, to CPU.
- `ram_a` output 17: RAM address, equal to `mem_a[16:0]`.
- `ram_wdata` output 8: RAM write data.
- `ram_we` output 1: RAM write enable.
- `ram_rdata` input 8: RAM read data, one-cycle latency.
- `tx_data` output 8: UART TX byte.
- `tx_valid` output 1: TX byte available.
- `tx_ready` input 1: UART accepts the byte this cycle.
- `rx_data` input 8: UART RX byte.
- `rx_valid` input 1: RX byte available.
- `rx_ready` output 1: pop RX byte, single-cycle pulse.
- `tx_overflow` output 1: sticky; a TX push was dropped.
- `program_finish` output 1: sticky; program stop complete.

## Operation
- Decode:
  - RAM region: `mem_a[17]==0`.
  - IO region: `mem_a[17:16]==2'b11`.
  - Hole: `mem_a[17:16]==2'b10`. Writes are ignored; reads return 0x00.
  - An access is "active" only when `rdy_in` is high.
- RAM access:
  - `ram_a` and `ram_wdata` are combinational pass-throughs.
  - `ram_we = rdy_in & mem_wr & RAM region`.
- Read-select register `sel_ram_q` is set each cycle to (active read to RAM region).
- `mem_din` mux: `ram_rdata` when `sel_ram_q`; otherwise `io_rdata_q`.
- IO reads (registered into `io_rdata_q`):
  - 0x30000: if `rx_valid`, capture `rx_data` and assert `rx_ready` in the same cycle. Otherwise return 0x00 with no pop.
  - 0x30004: return `cnt[7:0]` and snapshot `cnt` into `snap`.
  - 0x30005 / 0x30006 / 0x30007: return `snap[15:8]` / `snap[23:16]` / `snap[31:24]`.
  - Any other IO address, or a non-IO read: 0x00.
- Cycle counter `cnt`: 32-bit, increments every cycle regardless of `rdy_in`, wraps 0xFFFFFFFF→0.
- IO writes:
  - 0x30000 with nonzero data: push to the TX FIFO. Data 0x00 is ignored.
  - 0x30004 (any data): push 0x00 to the TX FIFO and enter FLUSH.
  - Any other IO address: ignored.
  - A push while count==TX_DEPTH is dropped and sets `tx_overflow`.
- TX FIFO:
  - Circular buffer with wrapping read/write pointers and a count of `clog2(TX_DEPTH)+1` bits.
  - `tx_valid = count!=0`; `tx_data` = head entry.
  - Pop on `tx_valid & tx_ready`.
  - Simultaneous push and pop leaves count unchanged. This is legal even at count==TX_DEPTH (pop first, so no drop).
  - `io_buffer_full = count >= TX_DEPTH-1`, leaving one slot for a write already in flight.
- State machine:
  - RUN: normal operation.
  - RUN→FLUSH on an active write to 0x30004.
  - FLUSH: further TX writes are ignored; RX and counter reads still work.
  - FLUSH→DONE when count==0.
  - DONE: `program_finish=1`, all writes ignored. Left only by reset.
  - A second 0x30004 write in FLUSH is ignored.

## Timing
- Reset values: `mem_din`=0x00 (`sel_ram_q`=0, `io_rdata_q`=0), `io_buffer_full`=0, `tx_valid`=0, `rx_ready`=0, `tx_overflow`=0, `program_finish`=0, `cnt`=0, FIFO empty, state RUN.
- `ram_we`, `ram_a` and `ram_wdata` are combinational, so during reset `ram_we` follows `rdy_in & mem_wr & RAM region`.
- Read latency is exactly 1 cycle for both RAM and IO. Back-to-back reads in consecutive cycles are supported.
- `rx_ready` is combinational: high only in the cycle of an active read of 0x30000 with `rx_valid`=1.
- A FIFO push in cycle N makes `tx_valid` visible in N+1. `io_buffer_full` updates the cycle after the count changes.
- The counter value returned for a read of 0x30004 in cycle N is `cnt` at cycle N, which equals N cycles since reset release.
- Reset mid-FLUSH returns to RUN with an empty FIFO. Bytes not yet drained are lost.

## Test plan
- Write 0x5A to 0x00010 then read 0x00010 → `ram_we` pulse with `ram_a`=0x10; `mem_din`=0x5A one cycle after the read.
- Write 'A' (0x41), 0x00, then 'B' to 0x30000 with `tx_ready`=1 → TX emits 0x41 then 0x42; the 0x00 never appears.
- Hold `tx_ready`=0 and write 8 nonzero bytes (`TX_DEPTH`=8) → `io_buffer_full`=1 after the 7th; the 9th write sets `tx_overflow`; drained order matches write order.
- With `rx_valid`=1 and `rx_data`=0x33, read 0x30000 → `rx_ready` pulses once, `mem_din`=0x33 next cycle. With `rx_valid`=0 → 0x00 and no pulse.
- Read 0x30004–0x30007 after 0x01020304 cycles → bytes 0x04, 0x03, 0x02, 0x01, consistent despite the counter advancing between reads.
- Queue 3 bytes, write 0x30004, then write 0x41 → the 3 bytes drain followed by 0x00, the 0x41 is ignored, and `program_finish` rises the cycle after the FIFO empties.
